// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: operands are captured on an accepted START and
// shifted LSB-first through a one-bit subtract cell, giving DIFF = A - B and BORROW_OUT.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             READY,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BORROW_OUT
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sha_q, sha_d;
   logic [WIDTH-1:0] shb_q, shb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;

   logic hs0_d, hs0_b, cell_d, hs1_b, cell_bout;

   // Full subtract cell: two half subtractors, borrows merged by an OR gate.
   hs_1b u_hs0 (.a(sha_q[0]), .b(shb_q[0]), .d(hs0_d),  .bout(hs0_b));
   hs_1b u_hs1 (.a(hs0_d),    .b(borrow_q), .d(cell_d), .bout(hs1_b));
   assign cell_bout = hs0_b | hs1_b;

   always_comb begin
      state_d  = state_q;
      sha_d    = sha_q;
      shb_d    = shb_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               sha_d    = A;
               shb_d    = B;
               diff_d   = '0;
               cnt_d    = '0;
               borrow_d = 1'b0;
               bout_d   = 1'b0;
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            sha_d    = sha_q >> 1;
            shb_d    = shb_q >> 1;
            diff_d   = {cell_d, diff_q[WIDTH-1:1]};
            borrow_d = cell_bout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               bout_d  = cell_bout;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         sha_q    <= '0;
         shb_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sha_q    <= sha_d;
         shb_q    <= shb_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
      end
   end

   assign READY      = (state_q != ST_RUN);
   assign BUSY       = (state_q == ST_RUN);
   assign DONE       = (state_q == ST_DONE);
   assign DIFF       = diff_q;
   assign BORROW_OUT = bout_q;

endmodule

// One-bit half subtractor: d = a - b, bout set when a borrow is needed.
module hs_1b (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);
   assign d    = a ^ b;
   assign bout = ~a & b;
endmodule
